// File: rtl/quad_encoder_gen.sv
// Quadrature A/B step generator: queues signed step requests and plays each one
// out as a full four-edge Gray cycle at a programmable edge spacing.
module quad_encoder_gen #(
    parameter int p_DIV_WIDTH = 16,
    parameter int p_CNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_step,
    input  logic                   i_cw,
    input  logic [p_DIV_WIDTH-1:0] iv_div,
    output logic                   o_phase_a,
    output logic                   o_phase_b,
    output logic                   o_busy,
    output logic [p_CNT_WIDTH-1:0] ov_pending,
    output logic                   o_ovf
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [p_DIV_WIDTH-1:0] c_div_one = p_DIV_WIDTH'(1);
    localparam logic signed [p_CNT_WIDTH:0] c_one  = (p_CNT_WIDTH+1)'(1);
    localparam logic signed [p_CNT_WIDTH:0] c_mone = '1;

    logic [0:0]             state_q, state_d;
    logic [p_DIV_WIDTH-1:0] timer_q, timer_d;
    logic [p_DIV_WIDTH-1:0] div_q, div_d;
    logic [1:0]             edge_q, edge_d;
    logic                   dir_q, dir_d;
    logic                   a_q, a_d;
    logic                   b_q, b_d;
    logic                   ovf_q, ovf_d;
    logic [p_CNT_WIDTH-1:0] pend_q, pend_d;

    logic                          start;
    logic signed [p_CNT_WIDTH:0]   pend_ext;
    logic signed [p_CNT_WIDTH:0]   req_ext;
    logic signed [p_CNT_WIDTH:0]   start_ext;
    logic signed [p_CNT_WIDTH:0]   sum_nreq;
    logic signed [p_CNT_WIDTH:0]   sum_req;

    // Pending counter: one guard bit detects leaving the signed range.
    always_comb begin
        start     = (state_q == ST_IDLE) && (pend_q != '0);
        pend_ext  = {pend_q[p_CNT_WIDTH-1], pend_q};
        req_ext   = '0;
        if (i_step) begin
            req_ext = i_cw ? c_one : c_mone;
        end
        start_ext = '0;
        if (start) begin
            start_ext = pend_q[p_CNT_WIDTH-1] ? c_mone : c_one;
        end
        sum_nreq  = pend_ext - start_ext;
        sum_req   = sum_nreq + req_ext;
        ovf_d     = 1'b0;
        pend_d    = sum_req[p_CNT_WIDTH-1:0];
        if (sum_req[p_CNT_WIDTH] != sum_req[p_CNT_WIDTH-1]) begin
            pend_d = sum_nreq[p_CNT_WIDTH-1:0];
            ovf_d  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        div_d   = div_q;
        edge_d  = edge_q;
        dir_d   = dir_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    dir_d   = ~pend_q[p_CNT_WIDTH-1];
                    div_d   = (iv_div == '0) ? c_div_one : iv_div;
                    timer_d = (iv_div == '0) ? c_div_one : iv_div;
                    edge_d  = 2'd0;
                end
            end
            ST_RUN: begin
                if (timer_q == c_div_one) begin
                    // Gray rotation; the fourth transition lands back on 00.
                    if (dir_q) begin
                        a_d = ~b_q;
                        b_d = a_q;
                    end else begin
                        a_d = b_q;
                        b_d = ~a_q;
                    end
                    timer_d = div_q;
                    edge_d  = edge_q + 2'd1;
                    if (edge_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - c_div_one;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            div_q   <= '0;
            edge_q  <= 2'd0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign o_phase_a  = a_q;
    assign o_phase_b  = b_q;
    assign o_busy     = (state_q == ST_RUN);
    assign ov_pending = pend_q;
    assign o_ovf      = ovf_q;

endmodule
